// File: rtl/ucsbece154_icache_cwf.sv
// N-way set-associative instruction cache with critical-word-first wrap refill,
// per-set round-robin replacement, mispredict-safe refill and saturating counters.
module ucsbece154_icache_cwf #(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 ReadEnable,
    input  logic [31:0]          ReadAddress,
    input  logic                 Mispredict,
    output logic [31:0]          Instruction,
    output logic                 Ready,
    output logic                 Busy,
    output logic [31:0]          MemReadAddress,
    output logic                 MemReadRequest,
    input  logic [31:0]          MemDataIn,
    input  logic                 MemDataReady,
    output logic [CNT_WIDTH-1:0] HitCount,
    output logic [CNT_WIDTH-1:0] MissCount
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_REFILL = 1'b1;

    // Storage; only the valid bits and replacement pointers are reset.
    logic [TAG_W-1:0]                    tag_q  [NUM_SETS][NUM_WAYS];
    logic [31:0]                         data_q [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]   valid_q;
    logic [NUM_SETS-1:0][WAY_W-1:0]      rr_q;

    logic [0:0]           state_q, state_d;
    logic [1:0]           rsync_q;
    logic                 abort_q;
    logic [OFF_W-1:0]     beat_q, crit_q;
    logic [IDX_W-1:0]     idx_q;
    logic [TAG_W-1:0]     ltag_q;
    logic [WAY_W-1:0]     victim_q;
    logic [31:0]          instr_q, maddr_q;
    logic                 ready_q, busy_q, mreq_q;
    logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_addr_bits;

    assign req_off          = ReadAddress[2 +: OFF_W];
    assign req_idx          = ReadAddress[2+OFF_W +: IDX_W];
    assign req_tag          = ReadAddress[31 -: TAG_W];
    assign unused_addr_bits = ^ReadAddress[1:0];

    logic             lookup, hit, inv_found, do_hit, do_miss, beat_fire, last_beat;
    logic [WAY_W-1:0] hit_way, victim;
    logic [OFF_W-1:0] fill_off;

    always_comb begin
        lookup    = (state_q == S_IDLE) && rsync_q[1] && ReadEnable && !Mispredict;
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        victim    = rr_q[req_idx];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        do_hit    = lookup && hit;
        do_miss   = lookup && !hit;
        beat_fire = (state_q == S_REFILL) && MemDataReady;
        last_beat = beat_fire && (beat_q == OFF_W'(BLOCK_WORDS - 1));
        fill_off  = crit_q + beat_q;  // wraps modulo the line length
        state_d   = state_q;
        if (do_miss)   state_d = S_REFILL;
        if (last_beat) state_d = S_IDLE;
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q    <= S_IDLE;
            rsync_q    <= '0;
            abort_q    <= 1'b0;
            beat_q     <= '0;
            crit_q     <= '0;
            idx_q      <= '0;
            ltag_q     <= '0;
            victim_q   <= '0;
            instr_q    <= '0;
            maddr_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            mreq_q     <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '0;
            rr_q       <= '0;
        end else begin
            rsync_q <= {rsync_q[0], 1'b1};
            state_q <= state_d;
            ready_q <= 1'b0;
            if (do_hit) begin
                instr_q <= data_q[req_idx][hit_way][req_off];
                ready_q <= 1'b1;
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
            end
            if (do_miss) begin
                idx_q    <= req_idx;
                ltag_q   <= req_tag;
                crit_q   <= req_off;
                victim_q <= victim;
                beat_q   <= '0;
                abort_q  <= 1'b0;
                maddr_q  <= {ReadAddress[31:2], 2'b00};
                mreq_q   <= 1'b1;
                busy_q   <= 1'b1;
                valid_q[req_idx][victim] <= 1'b0;
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
            end
            if (state_q == S_REFILL && Mispredict) abort_q <= 1'b1;
            if (beat_fire) begin
                beat_q <= beat_q + OFF_W'(1);
                if (beat_q == '0 && !abort_q && !Mispredict) begin
                    instr_q <= MemDataIn;
                    ready_q <= 1'b1;
                end
                // Completion must win over a mispredict arriving on the last beat.
                if (last_beat) begin
                    valid_q[idx_q][victim_q] <= 1'b1;
                    rr_q[idx_q]              <= rr_q[idx_q] + WAY_W'(1);
                    abort_q                  <= 1'b0;
                    mreq_q                   <= 1'b0;
                    busy_q                   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (beat_fire) data_q[idx_q][victim_q][fill_off] <= MemDataIn;
        if (last_beat) tag_q[idx_q][victim_q] <= ltag_q;
    end

    assign Instruction    = instr_q;
    assign Ready          = ready_q;
    assign Busy           = busy_q;
    assign MemReadAddress = maddr_q;
    assign MemReadRequest = mreq_q;
    assign HitCount       = hit_cnt_q;
    assign MissCount      = miss_cnt_q;
endmodule

// File: tb/tb_ucsbece154_icache_cwf.sv
// Directed + randomized bench for ucsbece154_icache_cwf against a set/way/pointer
// reference model; a second instance with 4-bit counters shares all inputs.
module tb_ucsbece154_icache_cwf;
    localparam int BW   = 4;
    localparam int WAYS = 4;
    localparam int SETS = 8;

    logic        Clk = 1'b0;
    logic        Reset_N, ReadEnable, Mispredict, MemDataReady;
    logic [31:0] ReadAddress, MemDataIn;
    logic [31:0] Instruction, MemReadAddress;
    logic        Ready, Busy, MemReadRequest;
    logic [15:0] HitCount, MissCount;
    logic [3:0]  HitCount4, MissCount4;
    logic [31:0] unused4_instr, unused4_maddr;
    logic        unused4_ready, unused4_busy, unused4_mreq;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    ucsbece154_icache_cwf dut (
        .Clk(Clk), .Reset_N(Reset_N), .ReadEnable(ReadEnable), .ReadAddress(ReadAddress),
        .Mispredict(Mispredict), .Instruction(Instruction), .Ready(Ready), .Busy(Busy),
        .MemReadAddress(MemReadAddress), .MemReadRequest(MemReadRequest),
        .MemDataIn(MemDataIn), .MemDataReady(MemDataReady),
        .HitCount(HitCount), .MissCount(MissCount));

    ucsbece154_icache_cwf #(.CNT_WIDTH(4)) dut4 (
        .Clk(Clk), .Reset_N(Reset_N), .ReadEnable(ReadEnable), .ReadAddress(ReadAddress),
        .Mispredict(Mispredict), .Instruction(unused4_instr), .Ready(unused4_ready),
        .Busy(unused4_busy), .MemReadAddress(unused4_maddr), .MemReadRequest(unused4_mreq),
        .MemDataIn(MemDataIn), .MemDataReady(MemDataReady),
        .HitCount(HitCount4), .MissCount(MissCount4));

    // Reference model: which tags live where, plus pointers and event counts.
    bit          m_valid [SETS][WAYS];
    logic [24:0] m_tag   [SETS][WAYS];
    int          m_rr    [SETS];
    int          m_hits, m_misses;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a >> 2) * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
        m_hits = 0;
        m_misses = 0;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[a[6:4]][w] && m_tag[a[6:4]][w] == a[31:7]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_victim(input int s);
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        return m_rr[s];
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts();
        chk("hit_count",    32'(HitCount),   32'(sat(m_hits, 65535)));
        chk("miss_count",   32'(MissCount),  32'(sat(m_misses, 65535)));
        chk("hit_count4",   32'(HitCount4),  32'(sat(m_hits, 15)));
        chk("miss_count4",  32'(MissCount4), 32'(sat(m_misses, 15)));
    endtask

    task automatic chk_reset_outs();
        chk("rst_ready", 32'(Ready), 0);
        chk("rst_busy",  32'(Busy), 0);
        chk("rst_mreq",  32'(MemReadRequest), 0);
        chk("rst_instr", Instruction, 0);
        chk("rst_maddr", MemReadAddress, 0);
        chk_counts();
    endtask

    task automatic idle_inputs();
        ReadEnable = 1'b0; Mispredict = 1'b0; MemDataReady = 1'b0;
        ReadAddress = '0; MemDataIn = '0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        #2 Reset_N = 1'b0;
        idle_inputs();
        model_reset();
        #1 chk_reset_outs();
        @(negedge Clk);
        Reset_N = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    // One fetch; on a miss the bench plays the SDRAM, returning beats in wrap order.
    task automatic fetch(input logic [31:0] addr, input int delay, input int mp_at,
                         input bit gappy, input bit re_during);
        int s, crit, beats, c0, rdy, exp_rdy, vic;
        logic [31:0] base;
        s = int'(addr[6:4]);
        crit = int'(addr[3:2]);
        base = {addr[31:4], 4'b0000};
        @(negedge Clk);
        ReadEnable = 1'b1; ReadAddress = addr; Mispredict = 1'b0;
        @(negedge Clk);
        ReadEnable = 1'b0;
        if (model_hit(addr)) begin
            m_hits++;
            chk("hit_ready", 32'(Ready), 1);
            chk("hit_instr", Instruction, mem_word(addr));
            chk("hit_busy",  32'(Busy), 0);
            @(negedge Clk);
            chk("hit_ready_pulse", 32'(Ready), 0);
        end else begin
            vic = model_victim(s);
            m_misses++;
            chk("miss_busy",  32'(Busy), 1);
            chk("miss_mreq",  32'(MemReadRequest), 1);
            chk("miss_maddr", MemReadAddress, {addr[31:2], 2'b00});
            chk("miss_ready", 32'(Ready), 0);
            beats = 0; c0 = -1; rdy = 0;
            for (int cyc = 0; cyc < 64 && beats < BW; cyc++) begin
                bit dr;
                dr = (cyc >= delay) && (!gappy || ((cyc - delay) % 2 == 0));
                MemDataReady = dr;
                MemDataIn = dr ? mem_word(base + 32'(((crit + beats) % BW) * 4)) : $urandom;
                Mispredict = (cyc == mp_at);
                ReadEnable = re_during;
                if (re_during) ReadAddress = $urandom;
                if (dr && beats == 0) c0 = cyc;
                @(negedge Clk);
                if (dr) beats++;
                if (Ready) begin
                    rdy++;
                    chk("crit_instr", Instruction, mem_word(addr));
                end
                chk("fill_busy",  32'(Busy), 32'(beats < BW));
                chk("fill_mreq",  32'(MemReadRequest), 32'(beats < BW));
                chk("fill_maddr", MemReadAddress, {addr[31:2], 2'b00});
            end
            MemDataReady = 1'b0; Mispredict = 1'b0; ReadEnable = 1'b0;
            exp_rdy = (mp_at >= 0 && mp_at <= c0) ? 0 : 1;
            chk("beats_done",   32'(beats), 32'(BW));
            chk("ready_pulses", 32'(rdy), 32'(exp_rdy));
            m_valid[s][vic] = 1'b1;
            m_tag[s][vic] = addr[31:7];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
        end
        chk_counts();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        Reset_N = 1'b0;
        idle_inputs();
        model_reset();
        #12 chk_reset_outs();
        @(negedge Clk);
        Reset_N = 1'b1;
        repeat (4) @(negedge Clk);

        // Cold miss with wrap order D2,D3,D0,D1, then a hit on word 0.
        fetch(32'h0001_0008, 0, -1, 1'b0, 1'b0);
        fetch(32'h0001_0000, 0, -1, 1'b0, 1'b0);

        // Mispredict together with a request in IDLE: nothing happens.
        @(negedge Clk);
        ReadEnable = 1'b1; Mispredict = 1'b1; ReadAddress = 32'h0009_0000;
        @(negedge Clk);
        ReadEnable = 1'b0; Mispredict = 1'b0;
        chk("mp_idle_ready", 32'(Ready), 0);
        chk("mp_idle_busy",  32'(Busy), 0);
        chk("mp_idle_mreq",  32'(MemReadRequest), 0);
        chk_counts();

        // Round-robin replacement in set 0: A..D fill, E and F evict ways 0 and 1.
        do_reset();
        for (int k = 1; k <= 6; k++) fetch(32'(k) << 7, 0, -1, 1'b0, 1'b0);
        fetch(32'h0000_0080, 0, -1, 1'b0, 1'b0);
        fetch(32'h0000_0184, 0, -1, 1'b0, 1'b0);
        fetch(32'h0000_0300, 0, -1, 1'b0, 1'b0);

        // Mispredict two cycles into refill, before beat 0: no delivery, line installed.
        do_reset();
        fetch(32'h0004_0024, 3, 1, 1'b0, 1'b0);
        fetch(32'h0004_0024, 0, -1, 1'b0, 1'b0);

        // Gappy burst with ReadEnable held during the fill, then every word of the line.
        fetch(32'h0000_3014, 0, -1, 1'b1, 1'b1);
        for (int o = 0; o < BW; o++) fetch(32'h0000_3010 + 32'(o * 4), 0, -1, 1'b0, 1'b0);

        // Randomized traffic over two sets and six tags to force evictions.
        for (int i = 0; i < 80; i++) begin
            a = (32'($urandom_range(1, 6)) << 7) | (32'($urandom_range(0, 1)) << 4)
                | (32'($urandom_range(0, 3)) << 2);
            fetch(a, $urandom_range(0, 2),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a refill after two beats.
        @(negedge Clk);
        ReadEnable = 1'b1; ReadAddress = 32'h0000_5008;
        @(negedge Clk);
        ReadEnable = 1'b0;
        chk("mid_busy", 32'(Busy), 1);
        MemDataReady = 1'b1; MemDataIn = mem_word(32'h0000_5008);
        @(negedge Clk);
        MemDataIn = mem_word(32'h0000_500C);
        @(negedge Clk);
        MemDataReady = 1'b0;
        #2 Reset_N = 1'b0;
        model_reset();
        #1 chk_reset_outs();
        @(negedge Clk);
        Reset_N = 1'b1;
        repeat (4) @(negedge Clk);
        fetch(32'h0000_5008, 0, -1, 1'b0, 1'b0);

        // Twenty hits: the 4-bit instance saturates at 15.
        for (int i = 0; i < 20; i++) fetch(32'h0000_5000 + 32'((i % BW) * 4), 0, -1, 1'b0, 1'b0);
        chk("sat_hit4", 32'(HitCount4), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
